// File: rtl/ps2_pkg.sv
// Shared types for the PS/2 receive path.
// Frame FSM states and frame geometry.
package ps2_pkg;

  localparam int PS2_DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_e;

endpackage

// File: rtl/ps2_fifo.sv
// Small synchronous FIFO for received scancodes.
// Pointers carry a wrap bit so full and empty fall out of a compare.
module ps2_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic [W-1:0]  data_i,
  input  logic          pop_i,
  output logic [W-1:0]  data_o,
  output logic [AW:0]   count_o,
  output logic          full_o
);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q, wr_d;
  logic [AW:0]  rd_q, rd_d;
  logic         empty;
  logic         push_ok;
  logic         pop_ok;

  assign empty  = (wr_q == rd_q);
  assign full_o = (wr_q[AW] != rd_q[AW]) &&
                  (wr_q[AW-1:0] == rd_q[AW-1:0]);

  // A pop in the same cycle frees the slot the push needs.
  assign pop_ok  = pop_i & ~empty;
  assign push_ok = push_i & (~full_o | pop_ok);

  assign wr_d = push_ok ? wr_q + 1'b1 : wr_q;
  assign rd_d = pop_ok  ? rd_q + 1'b1 : rd_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_q[AW-1:0]] <= data_i;
    end
  end

  assign data_o  = mem_q[rd_q[AW-1:0]];
  assign count_o = wr_q - rd_q;

endmodule

// File: rtl/ps2_receiver.sv
// PS/2 keyboard receiver: synchronise, deframe, check, queue, deliver.
// One scancode per ps2_key_pressed pulse, gated by ps2_ready.
module ps2_receiver
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000,
  localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          ps2_clock,
  input  logic          ps2_data,
  input  logic          ps2_ready,
  output logic          ps2_key_pressed,
  output logic [7:0]    ps2_out,
  output logic          frame_error,
  output logic          overflow,
  output logic [CW-1:0] fifo_count
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0] LAST_BIT = 3'(PS2_DATA_BITS - 1);

  logic [2:0]    clk_q;
  logic [1:0]    dat_q;
  logic          fall;
  logic          bit_in;

  ps2_state_e    state_q, state_d;
  logic [2:0]    bcnt_q, bcnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          par_q, par_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          timeout;
  logic          push;
  logic          err_d, err_q;

  logic          pop;
  logic          full;
  logic [7:0]    head;
  logic          kp_q;
  logic [7:0]    out_q;
  logic          ovf_q, ovf_d;

  // clk_q: [0],[1] synchroniser, [2] delay for edge detect.
  always_ff @(posedge clock) begin
    if (!reset) begin
      clk_q <= 3'b111;
      dat_q <= 2'b11;
    end else begin
      clk_q <= {clk_q[1:0], ps2_clock};
      dat_q <= {dat_q[0], ps2_data};
    end
  end

  assign fall   = clk_q[2] & ~clk_q[1];
  assign bit_in = dat_q[1];

  assign timeout = (state_q != IDLE) && !fall &&
                   (tcnt_q == TLAST);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (timeout) begin
      state_d = IDLE;
    end else if (fall) begin
      unique case (state_q)
        IDLE:   if (!bit_in) state_d = DATA;
        DATA:   if (bcnt_q == LAST_BIT) state_d = PARITY;
        PARITY: state_d = STOP;
        STOP:   state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    bcnt_d  = bcnt_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    push    = 1'b0;
    err_d   = timeout;
    tcnt_d  = (fall || state_q == IDLE) ? '0 : tcnt_q + TW'(1);
    if (fall && !timeout) begin
      unique case (state_q)
        IDLE: bcnt_d = '0;
        DATA: begin
          shreg_d = {bit_in, shreg_q[7:1]};
          bcnt_d  = bcnt_q + 3'd1;
        end
        PARITY: par_d = bit_in;
        STOP: begin
          // Odd parity over data plus parity bit, stop must be high.
          push  = bit_in & (^{shreg_q, par_q});
          err_d = ~push;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      bcnt_q  <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      tcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      bcnt_q  <= bcnt_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      tcnt_q  <= tcnt_d;
      err_q   <= err_d;
    end
  end

  assign pop   = (fifo_count != '0) && ps2_ready;
  assign ovf_d = ovf_q | (push & full & ~pop);

  ps2_fifo #(
    .W     (PS2_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clock),
    .rst_ni  (reset),
    .push_i  (push),
    .data_i  (shreg_q),
    .pop_i   (pop),
    .data_o  (head),
    .count_o (fifo_count),
    .full_o  (full)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      kp_q  <= 1'b0;
      out_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      kp_q  <= pop;
      ovf_q <= ovf_d;
      if (pop) begin
        out_q <= head;
      end
    end
  end

  assign ps2_key_pressed = kp_q;
  assign ps2_out         = out_q;
  assign frame_error     = err_q;
  assign overflow        = ovf_q;

endmodule

// File: tb/tb_ps2_receiver.sv
// Bench for ps2_receiver: directed PS/2 frames against a
// queue-based model of delivery, errors and overflow.
module tb_ps2_receiver;

  localparam int T = 50000;
  localparam int H = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pc = 1'b1;
  logic       pd = 1'b1;
  logic       rdy = 1'b1;
  logic       kp;
  logic [7:0] out;
  logic       err;
  logic       ovf;
  logic [3:0] cnt;

  always #5 clk = ~clk;

  ps2_receiver dut (
    .clock           (clk),
    .reset           (rst_n),
    .ps2_clock       (pc),
    .ps2_data        (pd),
    .ps2_ready       (rdy),
    .ps2_key_pressed (kp),
    .ps2_out         (out),
    .frame_error     (err),
    .overflow        (ovf),
    .fifo_count      (cnt)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;

  int         push_edge[$];
  logic [7:0] push_byte[$];
  int         err_edge[$];

  logic [7:0] mq[$];
  logic       m_kp = 1'b0;
  logic [7:0] m_out = 8'h00;
  logic       m_err = 1'b0;
  logic       m_ovf = 1'b0;

  logic [7:0] got[$];
  int         kp_edges[$];
  int         err_cnt = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at edge %0d",
               name, act, exp, cyc);
    end
  endtask

  // Model and per-cycle compare.
  initial begin
    logic       p;
    logic [7:0] b;
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        mq.delete();
        push_edge.delete();
        push_byte.delete();
        err_edge.delete();
        m_kp  = 1'b0;
        m_out = 8'h00;
        m_err = 1'b0;
        m_ovf = 1'b0;
      end else begin
        p = (mq.size() != 0) && rdy;
        m_kp = p;
        if (p) m_out = mq.pop_front();
        m_err = 1'b0;
        if (err_edge.size() != 0 && err_edge[0] == cyc) begin
          void'(err_edge.pop_front());
          m_err = 1'b1;
        end
        if (push_edge.size() != 0 && push_edge[0] == cyc) begin
          void'(push_edge.pop_front());
          b = push_byte.pop_front();
          if (mq.size() < 8) mq.push_back(b);
          else m_ovf = 1'b1;
        end
      end
      #1;
      check("cycle", {17'd0, kp, out, err, ovf, cnt},
            {17'd0, m_kp, m_out, m_err, m_ovf, 4'(mq.size())});
      if (kp) begin
        got.push_back(out);
        kp_edges.push_back(cyc);
      end
      if (err) err_cnt++;
    end
  end

  // kind: 0 good frame, 1 bad frame, 2 abandoned (timeout), 3 abandoned (no effect)
  task automatic send_bits(input logic [10:0] bits, input int n,
                           input int kind, input logic [7:0] b,
                           output int k);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      pd = bits[i];
      repeat (H) @(negedge clk);
      pc = 1'b0;
      k = cyc + 1;
      if (i == n - 1) begin
        if (kind == 0) begin
          push_edge.push_back(k + 2);
          push_byte.push_back(b);
        end else if (kind == 1) begin
          err_edge.push_back(k + 2);
        end else if (kind == 2) begin
          err_edge.push_back(k + 2 + T);
        end
      end
      repeat (H) @(negedge clk);
      pc = 1'b1;
    end
    pd = 1'b1;
  endtask

  function automatic logic [10:0] frame(input logic [7:0] b,
                                        input logic flip);
    return {1'b1, (~^b) ^ flip, b, 1'b0};
  endfunction

  task automatic send(input logic [7:0] b, input logic flip,
                      output int k);
    send_bits(frame(b, flip), 11, flip ? 1 : 0, b, k);
  endtask

  initial begin
    int k;
    int n0;
    repeat (3) @(negedge clk);
    check("reset_state", {17'd0, kp, out, err, ovf, cnt}, 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Clean 0x1C
    send(8'h1C, 1'b0, k);
    repeat (10) @(negedge clk);
    check("clean_count", got.size(), 1);
    check("clean_out", out, 8'h1C);
    check("clean_latency", kp_edges[0] - k, 3);
    check("clean_noerr", err_cnt, 0);

    // 0xF0 then 0x1C
    send(8'hF0, 1'b0, k);
    send(8'h1C, 1'b0, k);
    repeat (10) @(negedge clk);
    check("seq_count", got.size(), 3);
    check("seq_first", got[1], 8'hF0);
    check("seq_second", got[2], 8'h1C);
    check("seq_fifo_empty", cnt, 0);

    // Bad parity, then good 0x1C
    send(8'h1C, 1'b1, k);
    repeat (10) @(negedge clk);
    check("parity_err", err_cnt, 1);
    check("parity_nodeliver", got.size(), 3);
    check("parity_fifo", cnt, 0);
    send(8'h1C, 1'b0, k);
    repeat (10) @(negedge clk);
    check("parity_recover", got.size(), 4);
    check("parity_recover_out", got[3], 8'h1C);

    // Timeout after start + 4 data bits
    send_bits(frame(8'h1C, 1'b0), 5, 2, 8'h00, k);
    repeat (T) @(negedge clk);
    check("timeout_err", err_cnt, 2);
    check("timeout_nodeliver", got.size(), 4);
    send(8'h1C, 1'b0, k);
    repeat (10) @(negedge clk);
    check("timeout_recover", got.size(), 5);
    check("timeout_recover_out", got[4], 8'h1C);

    // Overflow
    rdy = 1'b0;
    for (int i = 1; i <= 9; i++) send(8'(i), 1'b0, k);
    repeat (10) @(negedge clk);
    check("ovf_count", cnt, 8);
    check("ovf_flag", ovf, 1);
    n0 = got.size();
    rdy = 1'b1;
    repeat (20) @(negedge clk);
    check("ovf_delivered", got.size() - n0, 8);
    for (int i = 0; i < 8; i++) check("ovf_order", got[n0 + i], i + 1);
    check("ovf_back_to_back", kp_edges[n0 + 7] - kp_edges[n0], 7);
    check("ovf_sticky", ovf, 1);
    check("ovf_drained", cnt, 0);

    // Reset mid-frame after 4 data bits
    send_bits(frame(8'h1C, 1'b0), 5, 3, 8'h00, k);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midreset_state", {17'd0, kp, out, err, ovf, cnt}, 32'd0);
    n0 = got.size();
    send(8'h1C, 1'b0, k);
    repeat (10) @(negedge clk);
    check("midreset_deliver", got.size() - n0, 1);
    check("midreset_out", out, 8'h1C);
    check("midreset_latency", kp_edges[kp_edges.size() - 1] - k, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
